id_hazard_ctrl: RTL and testbench

- Scoreboard-based issue controller between the RV32I fetch output and the ID/register-read stage.
- Decodes source and destination register usage from each incoming instruction and tracks pending writes in a 32-entry busy scoreboard.
- Stalls on RAW/WAW hazards and drains the pipeline for FENCE/SYSTEM.
- Forwards accepted instructions through a one-entry issue register with valid/ready handshakes on both sides.

---
 rtl/id_hazard_if.sv | 26 ++
 rtl/id_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_if.sv
// Issue-side handshake bundle for id_hazard_ctrl: upstream fetch channel,
// downstream issue channel and writeback completion.
interface id_hazard_if #(
    parameter int XLEN = 32
);
    logic            id_valid_i;
    logic [XLEN-1:0] id_instr_i;
    logic            id_ready_o;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [XLEN-1:0] issue_instr_o;
    logic [4:0]      issue_rd_o;
    logic            issue_rd_we_o;
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;

    modport master (
        output id_valid_i, id_instr_i, issue_ready_i, wb_valid_i, wb_rd_i,
        input  id_ready_o, issue_valid_o, issue_instr_o, issue_rd_o, issue_rd_we_o
    );

    modport slave (
        input  id_valid_i, id_instr_i, issue_ready_i, wb_valid_i, wb_rd_i,
        output id_ready_o, issue_valid_o, issue_instr_o, issue_rd_o, issue_rd_we_o
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Scoreboard issue controller: decodes RV32I operand usage, stalls on RAW/WAW
// against a busy-register scoreboard, drains for FENCE/SYSTEM, one-entry issue register.
module id_hazard_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_sys_i,
    input  logic            rst_sys_n_i,
    id_hazard_if.slave      bus,
    input  logic            flush_i,
    output logic            illegal_o,
    output logic [NREG-1:0] busy_o,
    output logic [1:0]      state_o,
    output logic [31:0]     stall_cnt_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic [NREG-1:0] reg_onehot(input logic [4:0] idx);
        reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic            uses_rs1_s, uses_rs2_s, writes_raw_s, writes_rd_s;
    logic            drain_s, illegal_s;
    logic [NREG-1:0] wb_clear_s, flush_clear_s, set_s, eff_busy_s;
    logic            hazard_s, out_free_s, id_ready_s, accept_s;

    logic            issue_valid_q, issue_valid_d;
    logic [XLEN-1:0] issue_instr_q, issue_instr_d;
    logic [4:0]      issue_rd_q, issue_rd_d;
    logic            issue_rd_we_q, issue_rd_we_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            illegal_q, illegal_d;
    logic [1:0]      state_q, state_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    assign opcode_s = bus.id_instr_i[6:0];
    assign rs1_s    = bus.id_instr_i[19:15];
    assign rs2_s    = bus.id_instr_i[24:20];
    assign rd_s     = bus.id_instr_i[11:7];

    // Operand-usage decode of the presented instruction
    always_comb begin
        uses_rs1_s   = 1'b0;
        uses_rs2_s   = 1'b0;
        writes_raw_s = 1'b0;
        drain_s      = 1'b0;
        illegal_s    = 1'b0;
        case (opcode_s)
            OP_R: begin
                uses_rs1_s   = 1'b1;
                uses_rs2_s   = 1'b1;
                writes_raw_s = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                uses_rs1_s   = 1'b1;
                writes_raw_s = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: writes_raw_s = 1'b1;
            OP_FENCE, OP_SYSTEM:      drain_s      = 1'b1;
            default:                  illegal_s    = 1'b1;
        endcase
    end

    assign writes_rd_s = writes_raw_s & (rd_s != 5'd0);

    // A same-cycle writeback is bypassed so the waiting instruction issues without a bubble
    assign wb_clear_s    = (bus.wb_valid_i && (bus.wb_rd_i != 5'd0)) ? reg_onehot(bus.wb_rd_i) : {NREG{1'b0}};
    assign flush_clear_s = (flush_i && issue_valid_q && issue_rd_we_q) ? reg_onehot(issue_rd_q) : {NREG{1'b0}};
    assign eff_busy_s    = busy_q & ~wb_clear_s;

    assign hazard_s = (uses_rs1_s & eff_busy_s[rs1_s])
                    | (uses_rs2_s & eff_busy_s[rs2_s])
                    | (writes_rd_s & eff_busy_s[rd_s])
                    | (drain_s & ((eff_busy_s != {NREG{1'b0}}) | issue_valid_q));

    assign out_free_s = ~issue_valid_q | bus.issue_ready_i;
    assign id_ready_s = ~hazard_s & out_free_s & ~flush_i;
    assign accept_s   = bus.id_valid_i & id_ready_s;
    assign set_s      = (accept_s && writes_rd_s) ? reg_onehot(rd_s) : {NREG{1'b0}};

    // Next-state for issue register, scoreboard, status and stall counter
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        issue_rd_d    = issue_rd_q;
        issue_rd_we_d = issue_rd_we_q;
        if (accept_s) begin
            issue_valid_d = 1'b1;
            issue_instr_d = bus.id_instr_i;
            issue_rd_d    = rd_s;
            issue_rd_we_d = writes_rd_s;
        end else if (flush_i || bus.issue_ready_i) begin
            issue_valid_d = 1'b0;
            issue_instr_d = {XLEN{1'b0}};
            issue_rd_d    = 5'd0;
            issue_rd_we_d = 1'b0;
        end else begin
            issue_valid_d = issue_valid_q;
        end

        busy_d    = (busy_q & ~wb_clear_s & ~flush_clear_s) | set_s;
        busy_d[0] = 1'b0;

        illegal_d = accept_s & illegal_s;

        if (!bus.id_valid_i) begin
            state_d = ST_RUN;
        end else if (!id_ready_s && drain_s) begin
            state_d = ST_DRAIN;
        end else if (!id_ready_s) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end

        if (bus.id_valid_i && !id_ready_s && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
        if (!rst_sys_n_i) begin
            issue_valid_q <= 1'b0;
            issue_instr_q <= {XLEN{1'b0}};
            issue_rd_q    <= 5'd0;
            issue_rd_we_q <= 1'b0;
            busy_q        <= {NREG{1'b0}};
            illegal_q     <= 1'b0;
            state_q       <= ST_RUN;
            stall_cnt_q   <= 32'd0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_rd_q    <= issue_rd_d;
            issue_rd_we_q <= issue_rd_we_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.id_ready_o    = id_ready_s;
    assign bus.issue_valid_o = issue_valid_q;
    assign bus.issue_instr_o = issue_instr_q;
    assign bus.issue_rd_o    = issue_rd_q;
    assign bus.issue_rd_we_o = issue_rd_we_q;
    assign illegal_o         = illegal_q;
    assign busy_o            = busy_q;
    assign state_o           = state_q;
    assign stall_cnt_o       = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against an operand-level reference model.
module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        illegal;
    logic [31:0] busy;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    id_hazard_if bus_if ();

    id_hazard_ctrl dut (
        .clk_sys_i   (clk),
        .rst_sys_n_i (rst_n),
        .bus         (bus_if),
        .flush_i     (flush),
        .illegal_o   (illegal),
        .busy_o      (busy),
        .state_o     (state),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ir,
                         input logic wv, input logic [4:0] wr, input logic fl);
        bus_if.id_valid_i    = v;
        bus_if.id_instr_i    = ins;
        bus_if.issue_ready_i = ir;
        bus_if.wb_valid_i    = wv;
        bus_if.wb_rd_i       = wr;
        flush                = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit r1;
        bit r2;
        bit wd;
        bit drain;
        bit ill;
    } use_t;

    function automatic use_t decode(input logic [6:0] op);
        use_t u = '0;
        case (op)
            7'b0110011: begin u.r1 = 1; u.r2 = 1; u.wd = 1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin u.r1 = 1; u.wd = 1; end
            7'b0100011, 7'b1100011: begin u.r1 = 1; u.r2 = 1; end
            7'b1101111, 7'b0110111, 7'b0010111: u.wd = 1;
            7'b0001111, 7'b1110011: u.drain = 1;
            default: u.ill = 1;
        endcase
        return u;
    endfunction

    bit          m_busy[32];
    bit          m_iv, m_we, m_ill;
    logic [31:0] m_instr;
    logic [4:0]  m_rd;
    logic [1:0]  m_st;
    logic [31:0] m_cnt;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
        m_iv = 0; m_we = 0; m_ill = 0;
        m_instr = 32'd0; m_rd = 5'd0; m_st = 2'd0; m_cnt = 32'd0;
    endtask

    function automatic bit pending(input int r, input logic wv, input logic [4:0] wr);
        return (r != 0) && m_busy[r] && !(wv && (int'(wr) == r));
    endfunction

    function automatic bit model_ready(input logic [31:0] ins, input logic ir,
                                       input logic wv, input logic [4:0] wr, input logic fl);
        use_t u = decode(ins[6:0]);
        bit hz = 0;
        bit any = 0;
        if (u.r1 && pending(int'(ins[19:15]), wv, wr)) hz = 1;
        if (u.r2 && pending(int'(ins[24:20]), wv, wr)) hz = 1;
        if (u.wd && pending(int'(ins[11:7]), wv, wr)) hz = 1;
        for (int r = 1; r < 32; r++) if (pending(r, wv, wr)) any = 1;
        if (u.drain && (any || m_iv)) hz = 1;
        return !hz && (!m_iv || ir) && !fl;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] ins, input logic ir,
                              input logic wv, input logic [4:0] wr, input logic fl, input bit rdy);
        use_t u = decode(ins[6:0]);
        bit acc = v && rdy;
        int rd = int'(ins[11:7]);
        for (int r = 1; r < 32; r++) begin
            if (wv && int'(wr) == r) m_busy[r] = 0;
            if (fl && m_iv && m_we && int'(m_rd) == r) m_busy[r] = 0;
            if (acc && u.wd && rd == r) m_busy[r] = 1;
        end
        if (acc) begin
            m_iv = 1; m_instr = ins; m_rd = ins[11:7]; m_we = u.wd && (rd != 0);
        end else if (fl || ir) begin
            m_iv = 0; m_instr = 32'd0; m_rd = 5'd0; m_we = 0;
        end
        m_ill = acc && u.ill;
        if (!v) m_st = 2'd0;
        else if (!rdy && u.drain) m_st = 2'd2;
        else if (!rdy) m_st = 2'd1;
        else m_st = 2'd0;
        if (v && !rdy && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] b = 32'd0;
        for (int r = 0; r < 32; r++) b[r] = m_busy[r];
        return b;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        ir;
        logic        wv;
        logic [4:0]  wr;
        logic        e_ready;
        logic        e_iv;
        logic        e_we;
        logic [31:0] e_busy;
        logic [1:0]  e_st;
    } vec_t;

    vec_t        tbl[15];
    logic [6:0]  ops[12];
    int          exp_cnt;

    initial begin
        tbl[0]  = '{1'b1, 32'h002082B3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 2'd0};
        tbl[1]  = '{1'b1, 32'h40328333, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 2'd1};
        tbl[2]  = '{1'b1, 32'h40328333, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 2'd0};
        tbl[3]  = '{1'b0, 32'h00000013, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        tbl[4]  = '{1'b1, 32'h00100013, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        tbl[5]  = '{1'b1, 32'h00002383, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 2'd0};
        tbl[6]  = '{1'b1, 32'h00702223, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 2'd1};
        tbl[7]  = '{1'b1, 32'h00702223, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 2'd1};
        tbl[8]  = '{1'b1, 32'h00702223, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        tbl[9]  = '{1'b0, 32'h00000013, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        tbl[10] = '{1'b1, 32'h00100413, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 2'd0};
        tbl[11] = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 2'd2};
        tbl[12] = '{1'b1, 32'h0000000F, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        tbl[13] = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'd2};
        tbl[14] = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};

        // reset values
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        chk("rst_issue_valid", bus_if.issue_valid_o, 1'b0);
        chk("rst_issue_instr", bus_if.issue_instr_o, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_state", state, 2'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].ins, tbl[i].ir, tbl[i].wv, tbl[i].wr, 1'b0);
            #1;
            chk($sformatf("vec%0d_ready", i), bus_if.id_ready_o, tbl[i].e_ready);
            if (tbl[i].v && !tbl[i].e_ready) exp_cnt++;
            tick();
            chk($sformatf("vec%0d_issue_valid", i), bus_if.issue_valid_o, tbl[i].e_iv);
            chk($sformatf("vec%0d_rd_we", i), bus_if.issue_rd_we_o, tbl[i].e_we);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_state", i), state, tbl[i].e_st);
        end
        chk("vec_stall_cnt", stall_cnt, 32'(exp_cnt));

        // async reset while busy=0xF00 and issue register full
        for (int r = 8; r < 12; r++) begin
            drive(1'b1, 32'h0010_0013 | (32'(r) << 7), 1'b1, 1'b0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("pre_rst_busy", busy, 32'h0000_0F00);
        chk("pre_rst_issue_valid", bus_if.issue_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_issue_valid", bus_if.issue_valid_o, 1'b0);
        chk("async_rst_instr", bus_if.issue_instr_o, 32'd0);
        chk("async_rst_rd", bus_if.issue_rd_o, 5'd0);
        chk("async_rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();

        // downstream backpressure for 3 cycles
        drive(1'b1, 32'h00100093, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        exp_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00100113, 1'b0, 1'b0, 5'd0, 1'b0);
            #1;
            chk($sformatf("bp%0d_ready", k), bus_if.id_ready_o, 1'b0);
            exp_cnt++;
            tick();
            chk($sformatf("bp%0d_instr", k), bus_if.issue_instr_o, 32'h00100093);
            chk($sformatf("bp%0d_state", k), state, 2'd1);
        end
        chk("bp_stall_cnt", stall_cnt, 32'(exp_cnt));
        drive(1'b1, 32'h00100113, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("bp_release_instr", bus_if.issue_instr_o, 32'h00100113);

        // stall counter saturation
        drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        force dut.stall_cnt_d = 32'hFFFF_FFFE;
        tick();
        release dut.stall_cnt_d;
        #1;
        chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
        drive(1'b1, 32'h00100213, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 32'h00100293, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("sat_reach", stall_cnt, 32'hFFFF_FFFF);
        tick();
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();

        // illegal opcode pulse
        drive(1'b1, 32'h0000_007F, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("illegal_pulse", illegal, 1'b1);
        chk("illegal_issued", bus_if.issue_valid_o, 1'b1);
        drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("illegal_one_cycle", illegal, 1'b0);

        // flush squashes the issue register and its busy bit
        drive(1'b1, 32'h00100513, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("flush_pre_busy10", busy[10], 1'b1);
        drive(1'b1, 32'h00100593, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        chk("flush_blocks_ready", bus_if.id_ready_o, 1'b0);
        tick();
        chk("flush_issue_valid", bus_if.issue_valid_o, 1'b0);
        chk("flush_busy10", busy[10], 1'b0);
        chk("flush_busy11", busy[11], 1'b0);

        // randomized traffic against the model
        drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        v, ir, wv, fl;
            logic [31:0] ins;
            logic [4:0]  wr;
            bit          rdy;
            v   = ($urandom_range(0, 9) < 8);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ir  = ($urandom_range(0, 9) < 7);
            wv  = ($urandom_range(0, 9) < 4);
            wr  = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 19) == 0);
            drive(v, ins, ir, wv, wr, fl);
            rdy = model_ready(ins, ir, wv, wr, fl);
            #1;
            chk("rnd_ready", bus_if.id_ready_o, rdy);
            model_step(v, ins, ir, wv, wr, fl, rdy);
            tick();
            chk("rnd_issue_valid", bus_if.issue_valid_o, m_iv);
            chk("rnd_issue_instr", bus_if.issue_instr_o, m_instr);
            chk("rnd_issue_rd", bus_if.issue_rd_o, m_rd);
            chk("rnd_rd_we", bus_if.issue_rd_we_o, m_we);
            chk("rnd_busy", busy, model_busy_vec());
            chk("rnd_illegal", illegal, m_ill);
            chk("rnd_state", state, m_st);
            chk("rnd_stall_cnt", stall_cnt, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
